instr_loader: RTL
=================

# instr_loader

Boot-time program loader that writes instruction memory, the mirror of the fetch path that reads it. It holds the CPU in reset, accepts a byte stream over a valid/ready handshake, and assembles little-endian 32-bit words. Each word is written to instruction memory at consecutive byte addresses. After a trailing checksum passes, it releases the CPU.

## Interface
Parameters:
- ADDR_W, 8, instruction memory byte-address width; matches the PC[7:0] fetch address.
- MAX_WORDS, 64, largest accepted program, equal to 2^ADDR_W / 4.

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  a byte is offered on in_data.
- in_data  in  8  stream byte.
- in_ready  out  1  loader can accept a byte; transfer occurs when in_valid && in_ready at the clock edge.
- mem_we  out  1  one-cycle instruction memory write strobe.
- mem_addr  out  ADDR_W  byte address of the word being written; always a multiple of 4.
- mem_wdata  out  32  word being written.
- cpu_rst  out  1  reset to the CPU (high = held in reset).
- done  out  1  load completed with a good checksum (level).
- error  out  1  load failed (level).

## Operation
- Stream format:
  - Byte 0: count byte N, the number of words.
  - Next 4N bytes: data, little-endian; the first byte of each word goes to wdata[7:0].
  - Final byte: checksum, equal to the XOR of the count byte and every data byte.
- States: COUNT, DATA, CHECK, DONE, ERROR. Reset enters COUNT.
- COUNT: in_ready=1.
  - On accept, latch N and seed the running XOR with it.
  - N=0: go to CHECK.
  - N>MAX_WORDS: go to ERROR.
  - Otherwise: go to DATA.
- DATA: in_ready=1.
  - Each accepted byte is XORed into the checksum and shifted into the assembler.
  - On the 4th byte of a word, the next cycle registers mem_we=1, mem_wdata=word and mem_addr=word_index*4. word_index then increments.
  - After word N's 4th byte, go to CHECK.
- CHECK: in_ready=1.
  - Accepted byte equal to the running XOR: go to DONE.
  - Otherwise: go to ERROR.
- DONE: in_ready=0, done=1, cpu_rst=0. Terminal until rst.
- ERROR: in_ready=0, error=1, cpu_rst=1. Terminal until rst.
- Bytes offered while in_valid=0 are ignored. A partial word is never written.
- Widths:
  - word_index is 7 bits (0..64).
  - mem_addr = word_index[5:0] concatenated with 2'b00, so no wrap occurs for N≤64.

## Timing
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst=1, done=0, error=0. in_ready rises the cycle after rst deasserts.
- Throughput: one byte per cycle sustained. in_ready stays high during write-strobe cycles.
- Write latency: mem_we asserts exactly 1 cycle after the 4th byte of a word is accepted. It is high for exactly 1 cycle, with mem_addr and mem_wdata valid in the same cycle.
- Overlap: the last word's write cycle may coincide with acceptance of the checksum byte. Both complete.
- DONE/ERROR: entered the cycle after the checksum byte (or a bad count byte) is accepted. done and cpu_rst change in that same cycle, both registered.
- Reset mid-load: all outputs return to reset values on the next edge. The partial word and running XOR are discarded; memory contents already written are not touched.
- Flow control: in_valid held high across state exit is not consumed once in_ready=0.

## Structure
- Package loader_pkg holds:
  - state enum (COUNT, DATA, CHECK, DONE, ERROR)
  - MAX_WORDS
  - WORD_BYTES=4
- Sub-module byte_assembler: 32-bit little-endian shift register with 2-bit byte index. It outputs word_valid (one cycle) and word. instr_loader contains the FSM, word counter, checksum and output registers.

## Test plan
- N=1, bytes 0x01, 0x78, 0x56, 0x34, 0x12, checksum 0x01^0x78^0x56^0x34^0x12 = 0x09 → one strobe at addr 0x00, data 0x12345678; done=1 and cpu_rst=0 the cycle after the checksum byte.
- N=3, back-to-back bytes with in_valid constantly high → strobes at 0x00, 0x04, 0x08, each 1 cycle after the word's 4th byte; in_ready never drops before DONE.
- N=2 with random in_valid gaps → identical writes and final state as the gap-free case.
- Checksum off by one bit → no done, error=1, cpu_rst stays 1, in_ready=0.
- Count byte 0x41 (65) → ERROR the cycle after acceptance, no writes. Count 0x00 followed by checksum 0x00 → DONE with no writes.
- rst asserted after 6 data bytes of N=2 → exactly one write (addr 0x00) issued before reset. All outputs at reset values next cycle. A fresh N=1 load then writes addr 0x00.

Source files
------------

// File: rtl/loader_pkg.sv
// loader_pkg: shared state encoding and sizing for the boot-time program loader
package loader_pkg;
  localparam int MAX_WORDS = 64;
  localparam int WORD_BYTES = 4;
  typedef enum logic [2:0] {COUNT, DATA, CHECK, DONE, ERROR} state_t;
endpackage

// File: rtl/instr_loader_byte_assembler.sv
// byte_assembler: little-endian byte-to-word shift register with a one-cycle word_valid
module byte_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);
  logic [23:0] sr_q;
  logic [1:0]  idx_q;
  // the fourth byte completes the word combinationally so the write can be registered on its accept edge
  assign word_valid_o = en_i && idx_q == 2'(WORD_BYTES - 1);
  assign word_o = {byte_i, sr_q};
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= '0;
      idx_q <= '0;
    end else if (en_i) begin
      sr_q  <= {byte_i, sr_q[23:8]};
      idx_q <= idx_q + 2'd1;
    end
  end
endmodule

// File: rtl/instr_loader.sv
// instr_loader: streams a counted, checksummed program into instruction memory while holding the CPU in reset
module instr_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              error
);
  state_t            state_q, state_d;
  logic [ADDR_W-2:0] cnt_q, cnt_d, widx_q, widx_d;
  logic [7:0]        xor_q, xor_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              rdy_q, done_q, err_q, crst_q;
  logic              acc, asm_en, word_valid;
  logic [31:0]       word;
  assign acc = in_valid && rdy_q;
  assign asm_en = acc && state_q == DATA;
  byte_assembler u_asm (
    .clk          (clk),
    .rst          (rst),
    .en_i         (asm_en),
    .byte_i       (in_data),
    .word_valid_o (word_valid),
    .word_o       (word)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    widx_d  = widx_q;
    xor_d   = xor_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      COUNT: if (acc) begin
        cnt_d   = in_data[ADDR_W-2:0];
        xor_d   = in_data;
        widx_d  = '0;
        state_d = in_data == 8'd0 ? CHECK : (in_data > 8'(MAX_WORDS) ? ERROR : DATA);
      end
      DATA: if (acc) begin
        xor_d = xor_q ^ in_data;
        if (word_valid) begin
          we_d    = 1'b1;
          addr_d  = {widx_q[ADDR_W-3:0], 2'b00};
          wdata_d = word;
          widx_d  = widx_q + 1'b1;
          state_d = widx_d == cnt_q ? CHECK : DATA;
        end
      end
      CHECK: if (acc) state_d = in_data == xor_q ? DONE : ERROR;
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COUNT;
      cnt_q   <= '0;
      widx_q  <= '0;
      xor_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdy_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      crst_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      widx_q  <= widx_d;
      xor_q   <= xor_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdy_q   <= state_d inside {COUNT, DATA, CHECK};
      done_q  <= state_d == DONE;
      err_q   <= state_d == ERROR;
      crst_q  <= state_d != DONE;
    end
  end
  assign in_ready  = rdy_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign done      = done_q;
  assign error     = err_q;
  assign cpu_rst   = crst_q;
endmodule
